// File: rtl/pika_dmem_pkg.sv
// Shared constants for the data-memory responder: address map, STATUS layout, data width.
// Also provides the address decoder used by the responder.
package pika_dmem_pkg;

  localparam int unsigned DataWidth = 32;

  localparam logic [31:0] CycleAddr  = 32'h0000_1000;
  localparam logic [31:0] TxDataAddr = 32'h0000_1004;
  localparam logic [31:0] StatusAddr = 32'h0000_1008;

  localparam int unsigned StatusFullBit  = 0;
  localparam int unsigned StatusEmptyBit = 1;
  localparam int unsigned StatusCntLsb   = 2;
  localparam int unsigned StatusCntWidth = 3;
  localparam int unsigned StatusOvfBit   = 5;
  localparam int unsigned StatusBadBit   = 6;

  typedef enum logic [2:0] {
    RegionRam,
    RegionCycle,
    RegionTx,
    RegionStatus,
    RegionNone
  } region_e;

  // Byte-lane bits are dropped by the caller; decode works on word addresses.
  function automatic region_e decode_region(input logic [29:0] word_addr,
                                            input int unsigned ram_words);
    if (word_addr < 30'(ram_words))     return RegionRam;
    if (word_addr == CycleAddr[31:2])  return RegionCycle;
    if (word_addr == TxDataAddr[31:2]) return RegionTx;
    if (word_addr == StatusAddr[31:2]) return RegionStatus;
    return RegionNone;
  endfunction

endpackage

// File: rtl/tx_fifo.sv
// Small synchronous FIFO feeding the TX byte sink.
// A push is accepted when not full, or when a pop frees a slot in the same cycle.
module tx_fifo #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned WIDTH      = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        push,
  input  logic [WIDTH-1:0]            push_data,
  input  logic                        pop,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(FIFO_DEPTH):0] count,
  output logic [WIDTH-1:0]            head
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]  rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (do_push && !do_pop)      count_q <= count_q + CntW'(1);
      else if (do_pop && !do_push) count_q <= count_q - CntW'(1);
    end
  end

  assign full  = (count_q == CntW'(FIFO_DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/dmem_responder.sv
// Core data-port responder: word RAM, free-running cycle counter, TX byte FIFO and STATUS.
// Reads are combinational from registered state; all updates happen on the rising clock edge.
module dmem_responder
  import pika_dmem_pkg::*;
#(
  parameter int unsigned RAM_WORDS  = 64,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          dmem_addr,
  input  logic                 dmem_write_en,
  input  logic [DataWidth-1:0] dmem_val_out,
  output logic [DataWidth-1:0] dmem_val_in,
  output logic                 tx_valid,
  output logic [7:0]           tx_data,
  input  logic                 tx_ready,
  output logic                 bad_access
);

  localparam int unsigned RamAw = $clog2(RAM_WORDS);
  localparam int unsigned CntW  = $clog2(FIFO_DEPTH) + 1;

  region_e              region;
  logic [RamAw-1:0]     ram_idx;
  logic                 unused_addr;
  logic                 wr_ram, wr_cycle, wr_tx, wr_status;
  logic                 fifo_pop, fifo_full, fifo_empty;
  logic [CntW-1:0]      fifo_count;
  logic [7:0]           fifo_head;
  logic                 ovf_set, ovf_clr, bad_set, bad_clr;
  logic [DataWidth-1:0] status_word;

  logic [DataWidth-1:0] ram_q [RAM_WORDS];
  logic [31:0]          cycle_q;
  logic                 overflow_q;
  logic                 bad_access_q;

  assign region      = decode_region(dmem_addr[31:2], RAM_WORDS);
  assign ram_idx     = dmem_addr[RamAw+1:2];
  assign unused_addr = ^dmem_addr[1:0];

  assign wr_ram    = dmem_write_en && (region == RegionRam);
  assign wr_cycle  = dmem_write_en && (region == RegionCycle);
  assign wr_tx     = dmem_write_en && (region == RegionTx);
  assign wr_status = dmem_write_en && (region == RegionStatus);

  tx_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .WIDTH     (8)
  ) u_tx_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (wr_tx),
    .push_data(dmem_val_out[7:0]),
    .pop      (fifo_pop),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count),
    .head     (fifo_head)
  );

  assign tx_valid = ~fifo_empty;
  assign tx_data  = fifo_head;
  assign fifo_pop = tx_valid & tx_ready;

  // A same-cycle pop makes room, so only a push into a full, non-draining FIFO overflows.
  assign ovf_set = wr_tx & fifo_full & ~fifo_pop;
  assign ovf_clr = wr_status & dmem_val_out[StatusOvfBit];
  assign bad_set = (region == RegionNone);
  assign bad_clr = wr_status & dmem_val_out[StatusBadBit];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < RAM_WORDS; i++) ram_q[i] <= '0;
      cycle_q      <= '0;
      overflow_q   <= 1'b0;
      bad_access_q <= 1'b0;
    end else begin
      cycle_q      <= wr_cycle ? '0 : cycle_q + 32'd1;
      overflow_q   <= ovf_set | (overflow_q & ~ovf_clr);
      bad_access_q <= bad_set | (bad_access_q & ~bad_clr);
      if (wr_ram) ram_q[ram_idx] <= dmem_val_out;
    end
  end

  assign bad_access = bad_access_q;

  always_comb begin
    status_word                                   = '0;
    status_word[StatusFullBit]                    = fifo_full;
    status_word[StatusEmptyBit]                   = fifo_empty;
    status_word[StatusCntLsb +: StatusCntWidth]   = StatusCntWidth'(fifo_count);
    status_word[StatusOvfBit]                     = overflow_q;
    status_word[StatusBadBit]                     = bad_access_q;
  end

  always_comb begin
    dmem_val_in = '0;
    unique case (region)
      RegionRam:    dmem_val_in = ram_q[ram_idx];
      RegionCycle:  dmem_val_in = cycle_q;
      RegionStatus: dmem_val_in = status_word;
      default:      dmem_val_in = '0;
    endcase
  end

endmodule
